slave_port_arbiter: RTL and testbench
=====================================

# slave_port_arbiter

Sequencing controller for the two-master / one-slave IO cell. It watches the request bits of both master buses and the acknowledge bit of the slave response, and grants the slave to one master at a time. It drives the cell's `sel` plus a request gate, holds the grant until the slave acknowledges (or a timeout fires), then re-arbitrates round-robin. It sits beside each IO cell in the crossbar; one instance per slave port.

## Interface
- `TIMEOUT`, 255: cycles in BUSY without `s_ack` before the transaction is aborted. Legal range 1 to 2^`TIMEOUT_W`-1.
- `TIMEOUT_W`, 8: width of the timeout counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `m0_req`  in  1  master 0 request: bit 65 of master 0's 66-bit bus.
- `m1_req`  in  1  master 1 request: bit 65 of master 1's 66-bit bus.
- `s_ack`  in  1  slave acknowledge: bit 32 of the slave's 33-bit response.
- `sel`  out  1  IO cell select: 0 = master 0, 1 = master 1. Registered.
- `req_gate`  out  1  high only in BUSY; top level ANDs it into bit 65 of the muxed master bus. Registered.
- `gnt0`  out  1  master 0 owns the slave. Registered.
- `gnt1`  out  1  master 1 owns the slave. Registered.
- `timeout`  out  1  one-cycle pulse when a transaction is aborted. Registered.

## Operation
- States: IDLE, BUSY, RELEASE. Encoding is free.
- `last` register holds the most recently granted master. It resets to 1, so master 0 wins the first tie.

**IDLE**
- Outputs: `gnt0`=`gnt1`=`req_gate`=0; `sel` holds its previous value.
- If exactly one request is high, grant that master.
- If both are high, grant the master not equal to `last`.
- On a grant, at the next edge: state becomes BUSY, `sel` and `last` take the winner, the winner's `gnt` goes to 1, and `req_gate` goes to 1.
- If no request is high, stay in IDLE.

**BUSY**
- `sel` is frozen and requests are ignored.
- `s_ack`=1 at an edge: go to RELEASE, clear the grant and `req_gate`.
- A grant cannot be revoked by the master. If the owner drops its request before `s_ack`, the grant is still held until `s_ack` or timeout.

**RELEASE**
- Lasts exactly one cycle with no grant. This lets the finished master drop its request.
- Then return to IDLE.
- Requests seen during RELEASE are not arbitrated.

**Boundary cases**
- Both requests held continuously: grants alternate 0, 1, 0, …
- `s_ack` seen in IDLE or RELEASE: ignored.
- `rst_n` asserted mid-transaction: immediately go to IDLE with all outputs at reset values. No ack is awaited.

## Timing
- Reset values: `sel`=0, `gnt0`=0, `gnt1`=0, `req_gate`=0, `timeout`=0, state IDLE, `last`=1, counter 0.
- Grant latency: request high at edge N (in IDLE) gives grant outputs high after edge N. The slave first sees the gated request in cycle N+1.
- Release: `s_ack` at edge M drops the grant after edge M. The earliest next grant is after edge M+2.
- Minimum back-to-back transaction period: 3 cycles, assuming the slave acks in the first BUSY cycle.
- All outputs come from flops; there are no combinational paths from input to output.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.

**Defined**
- The counter clears on entry to BUSY and increments each BUSY cycle without `s_ack`.
- When the counter reaches `TIMEOUT` in BUSY, the next edge goes to RELEASE, clears the grant and `req_gate`, and pulses `timeout` for one cycle.
- If `s_ack` and the timeout occur in the same cycle, `s_ack` wins: normal release, no `timeout` pulse.

**Undefined**
- No counter is built, `timeout` is tied to 0, and BUSY waits for `s_ack` indefinitely.

## Test plan
- Reset, then `m0_req`=1 only: `sel`=0 and `gnt0`=1 one cycle later; `s_ack` 3 cycles later; `gnt0` drops; RELEASE lasts 1 cycle.
- Both requests held continuously with immediate acks: grants go m0, m1, m0, m1, with a grant period of 3 cycles.
- `m1` owns the slave and `m0_req` rises: `sel` stays 1 until after `m1`'s ack, then `m0` is granted 2 cycles after that ack.
- With `ARB_TIMEOUT_EN`, `TIMEOUT`=4, and no `s_ack`: the grant lasts exactly 4 cycles and `timeout` pulses once. A second run with `s_ack` in the same cycle as the timeout gives no pulse.
- `rst_n` pulsed low while BUSY: `gnt0`, `gnt1`, `req_gate` and `sel` go to 0 asynchronously, and the first grant after reset goes to m0 on a tie.

Source files
------------

// File: rtl/slave_port_arbiter_if.sv
// Handshake bundle between the master/slave request bits and the slave-port arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding cell's view.
interface slave_port_arbiter_if;
  logic m0_req;
  logic m1_req;
  logic s_ack;
  logic sel;
  logic req_gate;
  logic gnt0;
  logic gnt1;
  logic timeout;

  modport slave (
    input  m0_req, m1_req, s_ack,
    output sel, req_gate, gnt0, gnt1, timeout
  );

  modport master (
    output m0_req, m1_req, s_ack,
    input  sel, req_gate, gnt0, gnt1, timeout
  );
endinterface

// File: rtl/slave_port_arbiter.sv
// Round-robin two-master arbiter for one slave port: IDLE -> BUSY -> RELEASE, all outputs registered.
// Optional BUSY watchdog enabled by defining ARB_TIMEOUT_EN.
module slave_port_arbiter #(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  slave_port_arbiter_if.slave  bus
);

  if (TIMEOUT < 1 || TIMEOUT > (2 ** TIMEOUT_W) - 1) begin : g_bad_timeout
    $error("slave_port_arbiter: TIMEOUT out of range for TIMEOUT_W");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RELEASE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic r_last, r_sel, r_gnt0, r_gnt1, r_req_gate;
  logic w_last_nxt, w_sel_nxt, w_gnt0_nxt, w_gnt1_nxt, w_req_gate_nxt;
  logic w_win;

`ifdef ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_cnt;
  logic [TIMEOUT_W-1:0] w_cnt_nxt;
  logic                 r_timeout;
  logic                 w_timeout_nxt;
  logic                 w_to_hit;

  // Abort on the edge that would take the count to TIMEOUT, so the grant lasts exactly TIMEOUT cycles.
  assign w_to_hit = (r_cnt == TIMEOUT_W'(TIMEOUT - 1));
`endif

  // On a tie the master that did not win last time goes next.
  assign w_win = (bus.m0_req && bus.m1_req) ? ~r_last : bus.m1_req;

  always_comb begin
    w_state_nxt    = r_state;
    w_last_nxt     = r_last;
    w_sel_nxt      = r_sel;
    w_gnt0_nxt     = 1'b0;
    w_gnt1_nxt     = 1'b0;
    w_req_gate_nxt = 1'b0;
`ifdef ARB_TIMEOUT_EN
    w_cnt_nxt      = r_cnt;
    w_timeout_nxt  = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          w_state_nxt    = ST_BUSY;
          w_last_nxt     = w_win;
          w_sel_nxt      = w_win;
          w_gnt0_nxt     = ~w_win;
          w_gnt1_nxt     = w_win;
          w_req_gate_nxt = 1'b1;
`ifdef ARB_TIMEOUT_EN
          w_cnt_nxt      = '0;
`endif
        end
      end
      ST_BUSY: begin
`ifdef ARB_TIMEOUT_EN
        if (!bus.s_ack) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
`endif
        if (bus.s_ack) begin
          w_state_nxt = ST_RELEASE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (w_to_hit) begin
          w_state_nxt   = ST_RELEASE;
          w_timeout_nxt = 1'b1;
        end
`endif
        else begin
          w_gnt0_nxt     = r_gnt0;
          w_gnt1_nxt     = r_gnt1;
          w_req_gate_nxt = 1'b1;
        end
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_last     <= 1'b1;
      r_sel      <= 1'b0;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_req_gate <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_sel      <= w_sel_nxt;
      r_gnt0     <= w_gnt0_nxt;
      r_gnt1     <= w_gnt1_nxt;
      r_req_gate <= w_req_gate_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign bus.timeout = r_timeout;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.sel      = r_sel;
  assign bus.gnt0     = r_gnt0;
  assign bus.gnt1     = r_gnt1;
  assign bus.req_gate = r_req_gate;

endmodule

// File: tb/tb_slave_port_arbiter.sv
// Bench for slave_port_arbiter: transaction-level reference model compared every cycle,
// plus directed scenarios with literal expectations. Works with or without ARB_TIMEOUT_EN.
module tb_slave_port_arbiter;

  localparam int T_OUT = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  slave_port_arbiter_if bus ();

  slave_port_arbiter #(
    .TIMEOUT   (T_OUT),
    .TIMEOUT_W (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the slave (-1 = nobody), whether we are in the one-cycle
  // cooldown after a release, and how many BUSY cycles the current owner has used.
  int m_owner = -1;
  bit m_cool  = 1'b0;
  bit m_last  = 1'b1;
  bit m_sel   = 1'b0;
  int m_age   = 0;
  bit m_to    = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_cool = 1'b0; m_last = 1'b1; m_sel = 1'b0; m_age = 0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner >= 0) begin
        m_age++;
        if (bus.s_ack) begin
          m_owner = -1; m_cool = 1'b1;
        end else if (TO_EN && m_age == T_OUT) begin
          m_owner = -1; m_cool = 1'b1; m_to = 1'b1;
        end
      end else if (m_cool) begin
        m_cool = 1'b0;
      end else if (bus.m0_req || bus.m1_req) begin
        if (bus.m0_req && bus.m1_req) m_owner = m_last ? 0 : 1;
        else                          m_owner = bus.m1_req ? 1 : 0;
        m_last = (m_owner == 1);
        m_sel  = m_last;
        m_age  = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_gnt0",     32'(bus.gnt0),     32'(m_owner == 0));
      chk("model_gnt1",     32'(bus.gnt1),     32'(m_owner == 1));
      chk("model_req_gate", 32'(bus.req_gate), 32'(m_owner >= 0));
      chk("model_sel",      32'(bus.sel),      32'(m_sel));
      chk("model_timeout",  32'(bus.timeout),  32'(m_to));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    bus.s_ack  = 1'b0;

    // Reset state
    #2;
    chk("rst_sel",  32'(bus.sel), 0);
    chk("rst_gnt0", 32'(bus.gnt0), 0);
    chk("rst_gnt1", 32'(bus.gnt1), 0);
    chk("rst_gate", 32'(bus.req_gate), 0);
    chk("rst_to",   32'(bus.timeout), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick(1);

    // Single request from m0, ack three cycles into BUSY
    bus.m0_req = 1'b1;
    tick(1);
    chk("s1_gnt0", 32'(bus.gnt0), 1);
    chk("s1_sel",  32'(bus.sel), 0);
    chk("s1_gate", 32'(bus.req_gate), 1);
    tick(2);
    bus.s_ack = 1'b1;
    tick(1);
    bus.s_ack  = 1'b0;
    bus.m0_req = 1'b0;
    chk("s1_rel_gnt0", 32'(bus.gnt0), 0);
    chk("s1_rel_gate", 32'(bus.req_gate), 0);
    tick(1);
    chk("s1_idle_gnt0", 32'(bus.gnt0), 0);

    // Both held with immediate ack: m0 won last, so m1 first, then alternating every 3 cycles
    bus.m0_req = 1'b1;
    bus.m1_req = 1'b1;
    bus.s_ack  = 1'b1;
    tick(1);
    chk("rr_a_gnt1", 32'(bus.gnt1), 1);
    chk("rr_a_sel",  32'(bus.sel), 1);
    tick(1);
    chk("rr_rel_gnt", 32'({bus.gnt0, bus.gnt1}), 0);
    tick(2);
    chk("rr_b_gnt0", 32'(bus.gnt0), 1);
    chk("rr_b_sel",  32'(bus.sel), 0);
    tick(3);
    chk("rr_c_gnt1", 32'(bus.gnt1), 1);
    chk("rr_c_sel",  32'(bus.sel), 1);

    // m1 owns; m0 requests meanwhile; sel holds until m1's ack, m0 granted two edges later
    bus.s_ack  = 1'b0;
    bus.m1_req = 1'b0;
    bus.m0_req = 1'b1;
    tick(2);
    chk("hold_sel",  32'(bus.sel), 1);
    chk("hold_gnt1", 32'(bus.gnt1), 1);
    chk("hold_gnt0", 32'(bus.gnt0), 0);
    bus.s_ack = 1'b1;
    tick(1);
    bus.s_ack = 1'b0;
    chk("hold_rel_gnt1", 32'(bus.gnt1), 0);
    tick(1);
    chk("hold_idle_gnt0", 32'(bus.gnt0), 0);
    tick(1);
    chk("hold_next_gnt0", 32'(bus.gnt0), 1);
    chk("hold_next_sel",  32'(bus.sel), 0);
    bus.s_ack  = 1'b1;
    bus.m0_req = 1'b0;
    tick(1);
    bus.s_ack = 1'b0;
    tick(2);

    // No ack: watchdog aborts after exactly T_OUT BUSY cycles when built in
    bus.m1_req = 1'b1;
    tick(1);
    bus.m1_req = 1'b0;
    chk("to_gnt1_start", 32'(bus.gnt1), 1);
    tick(3);
    chk("to_gnt1_last", 32'(bus.gnt1), 1);
    tick(1);
    chk("to_gnt1_after", 32'(bus.gnt1), TO_EN ? 0 : 1);
    chk("to_pulse",      32'(bus.timeout), TO_EN ? 1 : 0);
    if (!TO_EN) begin
      bus.s_ack = 1'b1;
      tick(1);
      bus.s_ack = 1'b0;
    end
    tick(1);
    chk("to_pulse_end", 32'(bus.timeout), 0);
    tick(1);

    // Ack coincides with the timeout cycle: normal release, no pulse
    bus.m0_req = 1'b1;
    tick(1);
    bus.m0_req = 1'b0;
    chk("ta_gnt0_start", 32'(bus.gnt0), 1);
    tick(3);
    bus.s_ack = 1'b1;
    tick(1);
    bus.s_ack = 1'b0;
    chk("ta_gnt0_after", 32'(bus.gnt0), 0);
    chk("ta_no_pulse",   32'(bus.timeout), 0);
    tick(2);

    // Asynchronous reset while BUSY, then tie after reset goes to m0
    bus.m1_req = 1'b1;
    tick(1);
    chk("ar_gnt1", 32'(bus.gnt1), 1);
    chk("ar_sel",  32'(bus.sel), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt1_clr", 32'(bus.gnt1), 0);
    chk("ar_sel_clr",  32'(bus.sel), 0);
    chk("ar_gate_clr", 32'(bus.req_gate), 0);
    bus.m0_req = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    chk("ar_tie_gnt0", 32'(bus.gnt0), 1);
    chk("ar_tie_sel",  32'(bus.sel), 0);
    bus.s_ack  = 1'b1;
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    tick(1);
    bus.s_ack = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
